timer_seq_ctrl: RTL and testbench
=================================

TIMER_SEQ_CTRL -- requirements
Module: timer_seq_ctrl

Interface
REQ-001 SHALL have parameter DIV_SLOW, default 16: clock cycles per tick at speed 0.
REQ-002 SHALL have parameter DIV_MED, default 4: clock cycles per tick at speed 1.
REQ-003 SHALL have parameter DIV_FAST, default 1: clock cycles per tick at speed 2.
REQ-004 SHALL have parameter ALARM_CYCLES, default 32: alarm hold length, used only under the macro in REQ-024.
REQ-005 SHALL use one clock and an asynchronous, active-high reset; the polarity and synchronicity are fixed.
REQ-006 SHALL have the following ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start_stop  in  1  single-cycle press
- clear  in  1  single-cycle press
- mode  in  1  direction: 0 counts up, 1 counts down
- speed_up, speed_down  in  1 each  single-cycle presses
- adj_plus, adj_minus  in  1 each  single-cycle ±2-minute requests
- cnt_zero  in  1  counter reads 00:00
- cnt_lt2m  in  1  counter is below 02:00
- tick  out  1  one-cycle count enable
- dir  out  1  latched count direction
- hold  out  1  counter freeze
- cnt_clear  out  1  one-cycle counter clear
- add_pulse, sub_pulse  out  1 each  one-cycle adjust strobes
- speed  out  2  speed level, 0..2
- state  out  3  FSM state encoding
- alarm  out  1  expiry indicator

Function
REQ-007 FSM states SHALL be IDLE, RUN, PAUSE, ADJ and EXPIRED.
REQ-008 Input priority in any cycle SHALL be clear > start_stop > adjust > speed.
REQ-009 clear in any state SHALL pulse cnt_clear for one cycle, enter IDLE, and zero the prescaler.
REQ-010 IDLE + start_stop SHALL latch mode into dir and enter RUN, except when mode=1 and cnt_zero=1, where the FSM stays in IDLE.
REQ-011 RUN + start_stop SHALL enter PAUSE; PAUSE + start_stop SHALL re-enter RUN with dir unchanged.
REQ-012 mode SHALL be sampled only at the IDLE→RUN transition; changes in RUN or PAUSE SHALL be ignored.
REQ-013 An adjust request in RUN or PAUSE SHALL enter ADJ for exactly one cycle.
- In ADJ, add_pulse or sub_pulse asserts for that cycle.
- The FSM then returns to the state it came from.
REQ-014 sub_pulse SHALL be suppressed, with ADJ still visited, when cnt_lt2m=1.
REQ-015 adj_plus and adj_minus asserted in the same cycle SHALL both be ignored.
REQ-016 RUN with dir=1 and cnt_zero=1 SHALL enter EXPIRED on the next clock with no further tick.
- Up-count wrap at 59:59 is left to the counter and causes no state change.
REQ-017 EXPIRED SHALL assert alarm=1 and hold=1; start_stop or clear SHALL return it to IDLE.
REQ-018 hold SHALL be 1 in every state except RUN.
REQ-019 Prescaler SHALL count 0..DIV(speed)-1 only in RUN.
- tick = 1 when the count equals DIV-1, so the first tick arrives DIV cycles after entering RUN.
- With DIV_FAST=1, tick is high on every RUN cycle.
REQ-020 speed_up and speed_down SHALL saturate at 2 and 0 respectively.
- Any speed change zeroes the prescaler.
- Both asserted in the same cycle is ignored.
REQ-021 tick, cnt_clear, add_pulse and sub_pulse SHALL be mutually exclusive in any cycle.

Reset
REQ-022 On reset assertion, all of the following SHALL hold immediately:
- state=IDLE, dir=0, hold=1, speed=0, alarm=0, tick=0, cnt_clear=0, add_pulse=0, sub_pulse=0, prescaler=0.
REQ-023 Reset asserted mid-RUN or mid-ADJ SHALL abort without emitting any pending strobe.

Configuration
REQ-024 With ALARM_TIMEOUT_EN defined, EXPIRED SHALL return to IDLE automatically after ALARM_CYCLES cycles.
- The timeout counter zeroes on entering EXPIRED.
- Without the macro, EXPIRED persists until start_stop or clear, and no timeout counter is built.

Structure
REQ-025 Package clock_pkg SHALL hold:
- the state enum;
- the speed_t 2-bit typedef;
- SPEED_MAX=2;
- DIV selection constants.
REQ-026 The prescaler SHALL be a sub-module tick_prescaler, with ports: clk, reset, en, zero, div, tick.

Verification
REQ-027 With DIV_SLOW=16: reset, start_stop with mode=0 → tick at cycles 16, 32, 48 after entering RUN; hold=0; dir=0.
REQ-028 mode=1, start_stop, then raise cnt_zero after 3 ticks → EXPIRED next cycle, alarm=1, no 4th tick, hold=1.
REQ-029 In PAUSE, adj_minus with cnt_lt2m=1 → ADJ one cycle, sub_pulse=0, back to PAUSE; then adj_plus → add_pulse=1 for one cycle.
REQ-030 In RUN, clear and start_stop in the same cycle → cnt_clear=1 once, state=IDLE, no tick; three speed_up presses → speed=2.
REQ-031 Under ALARM_TIMEOUT_EN with ALARM_CYCLES=32: EXPIRED → IDLE after 32 cycles, alarm=0; without the macro → still EXPIRED at 100 cycles.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the timer sequencing controller: FSM states,
// speed levels and the per-speed prescaler divider selection.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_ADJ     = 3'd3,
    ST_EXPIRED = 3'd4
  } state_t;

  typedef logic [1:0] speed_t;

  localparam speed_t SPEED_SLOW = 2'd0;
  localparam speed_t SPEED_MED  = 2'd1;
  localparam speed_t SPEED_FAST = 2'd2;
  localparam speed_t SPEED_MAX  = SPEED_FAST;

  // Width of the prescaler count and divider bus.
  localparam int DIV_W = 16;

  function automatic logic [DIV_W-1:0] div_sel(input speed_t s,
                                               input int unsigned div_slow,
                                               input int unsigned div_med,
                                               input int unsigned div_fast);
    case (s)
      SPEED_SLOW: return DIV_W'(div_slow);
      SPEED_MED:  return DIV_W'(div_med);
      default:    return DIV_W'(div_fast);
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock prescaler: counts 0..div-1 while enabled and flags the last count as
// a one-cycle tick. A zero request overrides counting.
module tick_prescaler
  import clock_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         zero,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_end;

  assign at_end = (cnt_q == div - W'(1));
  assign tick   = en & at_end;

  // NOTE: next-state logic gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (zero)    cnt_d = '0;
    else if (en) cnt_d = at_end ? '0 : cnt_q + W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Timer sequencing controller: start/pause/adjust/expire FSM driving a
// minute:second counter. Define ALARM_TIMEOUT_EN to auto-clear the alarm.
module timer_seq_ctrl
  import clock_pkg::*;
#(
  parameter int DIV_SLOW     = 16,
  parameter int DIV_MED      = 4,
  parameter int DIV_FAST     = 1,
  parameter int ALARM_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       mode,
  input  logic       speed_up,
  input  logic       speed_down,
  input  logic       adj_plus,
  input  logic       adj_minus,
  input  logic       cnt_zero,
  input  logic       cnt_lt2m,
  output logic       tick,
  output logic       dir,
  output logic       hold,
  output logic       cnt_clear,
  output logic       add_pulse,
  output logic       sub_pulse,
  output logic [1:0] speed,
  output logic [2:0] state,
  output logic       alarm
);

  state_t state_q, ret_q;
  speed_t speed_q;
  logic   dir_q, hold_q, alarm_q, cnt_clear_q, add_q, sub_q;

  logic adj_req, spd_ok, spd_inc, spd_dec, run_start, pre_zero, pre_tick, tmo_done;
  logic [DIV_W-1:0] div;

  // A press only counts if no higher-priority press is present the same cycle.
  assign adj_req   = adj_plus ^ adj_minus;
  assign spd_ok    = ~clear & ~start_stop & ~adj_req;
  assign spd_inc   = spd_ok & speed_up & ~speed_down & (speed_q != SPEED_MAX);
  assign spd_dec   = spd_ok & speed_down & ~speed_up & (speed_q != SPEED_SLOW);
  assign run_start = ~clear & (state_q == ST_IDLE) & start_stop & ~(mode & cnt_zero);
  assign pre_zero  = clear | spd_inc | spd_dec | run_start;
  assign div       = div_sel(speed_q, DIV_SLOW, DIV_MED, DIV_FAST);

  tick_prescaler #(.W(DIV_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_RUN),
    .zero  (pre_zero),
    .div   (div),
    .tick  (pre_tick)
  );

  // No count may slip out while the counter is being cleared or is expiring.
  assign tick = pre_tick & ~clear & ~(dir_q & cnt_zero);

`ifdef ALARM_TIMEOUT_EN
  localparam int TMO_W = $clog2(ALARM_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      tmo_q <= '0;
    else if (state_q != ST_EXPIRED) tmo_q <= '0;
    else                            tmo_q <= tmo_q + TMO_W'(1);
  end

  assign tmo_done = (tmo_q == TMO_W'(ALARM_CYCLES - 1));
`else
  assign tmo_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_RUN;
      dir_q       <= 1'b0;
      hold_q      <= 1'b1;
      speed_q     <= SPEED_SLOW;
      alarm_q     <= 1'b0;
      cnt_clear_q <= 1'b0;
      add_q       <= 1'b0;
      sub_q       <= 1'b0;
    end else begin
      cnt_clear_q <= 1'b0;
      add_q       <= 1'b0;
      sub_q       <= 1'b0;

      if (spd_inc)      speed_q <= speed_q + speed_t'(1);
      else if (spd_dec) speed_q <= speed_q - speed_t'(1);

      if (clear) begin
        state_q     <= ST_IDLE;
        hold_q      <= 1'b1;
        alarm_q     <= 1'b0;
        cnt_clear_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (run_start) begin
              state_q <= ST_RUN;
              dir_q   <= mode;
              hold_q  <= 1'b0;
            end
          end
          ST_RUN: begin
            if (dir_q && cnt_zero) begin
              state_q <= ST_EXPIRED;
              alarm_q <= 1'b1;
              hold_q  <= 1'b1;
            end else if (start_stop) begin
              state_q <= ST_PAUSE;
              hold_q  <= 1'b1;
            end else if (adj_req) begin
              state_q <= ST_ADJ;
              ret_q   <= ST_RUN;
              hold_q  <= 1'b1;
              add_q   <= adj_plus;
              sub_q   <= adj_minus & ~cnt_lt2m;
            end
          end
          ST_PAUSE: begin
            if (start_stop) begin
              state_q <= ST_RUN;
              hold_q  <= 1'b0;
            end else if (adj_req) begin
              state_q <= ST_ADJ;
              ret_q   <= ST_PAUSE;
              add_q   <= adj_plus;
              sub_q   <= adj_minus & ~cnt_lt2m;
            end
          end
          ST_ADJ: begin
            state_q <= ret_q;
            hold_q  <= (ret_q != ST_RUN);
          end
          ST_EXPIRED: begin
            if (start_stop || tmo_done) begin
              state_q <= ST_IDLE;
              alarm_q <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            hold_q  <= 1'b1;
            alarm_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dir       = dir_q;
  assign hold      = hold_q;
  assign cnt_clear = cnt_clear_q;
  assign add_pulse = add_q;
  assign sub_pulse = sub_q;
  assign speed     = speed_q;
  assign state     = state_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Self-checking bench for timer_seq_ctrl: directed scenarios followed by random
// presses, every cycle compared against a behavioural model.
module tb_timer_seq_ctrl
  import clock_pkg::*;
;
  localparam int DIV_SLOW     = 16;
  localparam int DIV_MED      = 4;
  localparam int DIV_FAST     = 1;
  localparam int ALARM_CYCLES = 32;
  localparam logic [11:0] RESET_VEC = 12'h200;

  logic clk = 1'b0, reset = 1'b1;
  logic start_stop = 0, clear = 0, mode = 0, speed_up = 0, speed_down = 0;
  logic adj_plus = 0, adj_minus = 0, cnt_zero = 0, cnt_lt2m = 0;
  logic tick, dir, hold, cnt_clear, add_pulse, sub_pulse, alarm;
  logic [1:0] speed;
  logic [2:0] state;

  timer_seq_ctrl #(
    .DIV_SLOW(DIV_SLOW), .DIV_MED(DIV_MED), .DIV_FAST(DIV_FAST), .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .mode(mode),
    .speed_up(speed_up), .speed_down(speed_down), .adj_plus(adj_plus), .adj_minus(adj_minus),
    .cnt_zero(cnt_zero), .cnt_lt2m(cnt_lt2m), .tick(tick), .dir(dir), .hold(hold),
    .cnt_clear(cnt_clear), .add_pulse(add_pulse), .sub_pulse(sub_pulse), .speed(speed),
    .state(state), .alarm(alarm)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;

  // Behavioural model: m_n counts RUN cycles since the prescaler was last zeroed.
  state_t m_state, m_ret;
  logic   m_dir, m_clr, m_add, m_sub, last_tick;
  int     m_speed, m_n, m_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] obs_vec();
    return {tick, dir, hold, cnt_clear, add_pulse, sub_pulse, speed, state, alarm};
  endfunction

  function automatic logic [11:0] model_vec();
    int   d;
    logic t;
    d = (m_speed == 0) ? DIV_SLOW : (m_speed == 1) ? DIV_MED : DIV_FAST;
    t = (m_state == ST_RUN) && ((m_n % d) == d - 1) && !clear && !(m_dir && cnt_zero);
    return {t, m_dir, m_state != ST_RUN, m_clr, m_add, m_sub, 2'(m_speed), m_state,
            m_state == ST_EXPIRED};
  endfunction

  task automatic model_reset();
    m_state = ST_IDLE; m_ret = ST_RUN; m_dir = 0; m_clr = 0; m_add = 0; m_sub = 0;
    m_speed = 0; m_n = 0; m_exp = 0;
  endtask

  task automatic model_advance();
    logic   adj1, zero;
    state_t nxt;
    adj1 = adj_plus ^ adj_minus;
    zero = clear;
    nxt  = m_state;
    m_clr = clear; m_add = 0; m_sub = 0;
    if (!clear && !start_stop && !adj1 && (speed_up != speed_down)) begin
      if (speed_up && m_speed < 2)   begin m_speed++; zero = 1; end
      if (speed_down && m_speed > 0) begin m_speed--; zero = 1; end
    end
    if (clear) nxt = ST_IDLE;
    else case (m_state)
      ST_IDLE:
        if (start_stop && !(mode && cnt_zero)) begin nxt = ST_RUN; m_dir = mode; zero = 1; end
      ST_RUN:
        if (m_dir && cnt_zero) nxt = ST_EXPIRED;
        else if (start_stop) nxt = ST_PAUSE;
        else if (adj1) begin
          nxt = ST_ADJ; m_ret = ST_RUN; m_add = adj_plus; m_sub = adj_minus && !cnt_lt2m;
        end
      ST_PAUSE:
        if (start_stop) nxt = ST_RUN;
        else if (adj1) begin
          nxt = ST_ADJ; m_ret = ST_PAUSE; m_add = adj_plus; m_sub = adj_minus && !cnt_lt2m;
        end
      ST_ADJ: nxt = m_ret;
      ST_EXPIRED:
        if (start_stop) nxt = ST_IDLE;
`ifdef ALARM_TIMEOUT_EN
        else if (m_exp + 1 == ALARM_CYCLES) nxt = ST_IDLE;
`endif
      default: nxt = ST_IDLE;
    endcase
    if (zero) m_n = 0;
    else if (m_state == ST_RUN) m_n++;
    m_exp   = (m_state == ST_EXPIRED && nxt == ST_EXPIRED) ? m_exp + 1 : 0;
    m_state = nxt;
  endtask

  // Inputs are set just after a rising edge; outputs are compared on the falling edge.
  task automatic step();
    @(negedge clk);
    check("cycle", 32'(obs_vec()), 32'(model_vec()));
    check("strobe_excl", 32'($onehot0({tick, cnt_clear, add_pulse, sub_pulse})), 32'd1);
    last_tick = tick;
    model_advance();
    @(posedge clk);
    #1;
    start_stop = 0; clear = 0; speed_up = 0; speed_down = 0; adj_plus = 0; adj_minus = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tpos[$];
    int tick_cnt, guard;
    model_reset();
    #12;
    check("reset_vec", 32'(obs_vec()), 32'(RESET_VEC));
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    // Slow up-count: ticks on the 16th, 32nd and 48th RUN cycle.
    mode = 0; start_stop = 1; step();
    check("run_state", 32'(state), 32'(ST_RUN));
    check("run_hold", 32'(hold), 32'd0);
    check("run_dir", 32'(dir), 32'd0);
    for (int k = 0; k < 48; k++) begin
      step();
      if (last_tick) tpos.push_back(k);
    end
    check("tick_count", 32'(tpos.size()), 32'd3);
    check("tick_1st", 32'(tpos[0]), 32'd15);
    check("tick_2nd", 32'(tpos[1]), 32'd31);
    check("tick_3rd", 32'(tpos[2]), 32'd47);

    // clear beats start_stop; speed saturation.
    clear = 1; start_stop = 1; step();
    check("clr_no_tick", 32'(last_tick), 32'd0);
    check("clr_state", 32'(state), 32'(ST_IDLE));
    check("clr_pulse", 32'(cnt_clear), 32'd1);
    step();
    check("clr_once", 32'(cnt_clear), 32'd0);
    for (int i = 0; i < 3; i++) begin speed_up = 1; step(); end
    check("speed_max", 32'(speed), 32'd2);
    speed_up = 1; speed_down = 1; step();
    check("speed_both", 32'(speed), 32'd2);
    for (int i = 0; i < 3; i++) begin speed_down = 1; step(); end
    check("speed_min", 32'(speed), 32'd0);

    // Down-count expiry after three ticks.
    mode = 1; start_stop = 1; step();
    check("down_dir", 32'(dir), 32'd1);
    tick_cnt = 0; guard = 0;
    while (tick_cnt < 3 && guard < 200) begin
      step();
      if (last_tick) tick_cnt++;
      guard++;
    end
    check("down_ticks", 32'(tick_cnt), 32'd3);
    cnt_zero = 1; step();
    check("no_4th_tick", 32'(last_tick), 32'd0);
    check("exp_state", 32'(state), 32'(ST_EXPIRED));
    check("exp_alarm", 32'(alarm), 32'd1);
    check("exp_hold", 32'(hold), 32'd1);
`ifdef ALARM_TIMEOUT_EN
    repeat (ALARM_CYCLES - 1) step();
    check("tmo_before", 32'(state), 32'(ST_EXPIRED));
    step();
    check("tmo_state", 32'(state), 32'(ST_IDLE));
    check("tmo_alarm", 32'(alarm), 32'd0);
`else
    repeat (100) step();
    check("exp_persist", 32'(state), 32'(ST_EXPIRED));
    check("exp_persist_alarm", 32'(alarm), 32'd1);
    start_stop = 1; step();
    check("exp_exit", 32'(state), 32'(ST_IDLE));
    check("exp_exit_alarm", 32'(alarm), 32'd0);
`endif
    start_stop = 1; step();
    check("idle_zero_stay", 32'(state), 32'(ST_IDLE));
    cnt_zero = 0;

    // Adjust from PAUSE, including suppressed subtract and mode ignored.
    mode = 0; start_stop = 1; step();
    repeat (5) step();
    start_stop = 1; step();
    check("pause_state", 32'(state), 32'(ST_PAUSE));
    mode = 1; cnt_lt2m = 1; adj_minus = 1; step();
    check("adjm_state", 32'(state), 32'(ST_ADJ));
    check("adjm_sub_blocked", 32'(sub_pulse), 32'd0);
    step();
    check("adjm_back", 32'(state), 32'(ST_PAUSE));
    adj_plus = 1; step();
    check("adjp_state", 32'(state), 32'(ST_ADJ));
    check("adjp_add", 32'(add_pulse), 32'd1);
    step();
    check("adjp_back", 32'(state), 32'(ST_PAUSE));
    check("adjp_once", 32'(add_pulse), 32'd0);
    cnt_lt2m = 0; adj_minus = 1; step();
    check("adjm_sub", 32'(sub_pulse), 32'd1);
    step();
    adj_plus = 1; adj_minus = 1; step();
    check("adj_both", 32'(state), 32'(ST_PAUSE));
    start_stop = 1; step();
    check("resume_state", 32'(state), 32'(ST_RUN));
    check("resume_dir", 32'(dir), 32'd0);

    // Reset in the middle of an adjust strobe.
    adj_plus = 1; step();
    check("pre_rst_add", 32'(add_pulse), 32'd1);
    reset = 1; #1;
    check("rst_mid_adj", 32'(obs_vec()), 32'(RESET_VEC));
    model_reset();
    mode = 0; cnt_zero = 0; cnt_lt2m = 0;
    @(negedge clk); reset = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 3000; i++) begin
      start_stop = ($urandom_range(0, 7) == 0);
      clear      = ($urandom_range(0, 39) == 0);
      speed_up   = ($urandom_range(0, 7) == 0);
      speed_down = ($urandom_range(0, 7) == 0);
      adj_plus   = ($urandom_range(0, 9) == 0);
      adj_minus  = ($urandom_range(0, 9) == 0);
      cnt_lt2m   = $urandom_range(0, 1) == 1;
      cnt_zero   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
